// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: resolves operand forwarding, captures ID into EX one cycle later,
// converts stall/flush into bubbles and keeps saturating stall/flush counters. No backpressure beyond id_hold.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic [3:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       forward_a_src,
  input  logic [1:0]       forward_b_src,
  input  logic [XLEN-1:0]  ex_fwd_data,
  input  logic [XLEN-1:0]  mem_fwd_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             id_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            bubble;

  // Source indices are only consumed by the hazard unit; kept on the port list for a uniform ID bundle.
  logic unused_idx;
  assign unused_idx = ^{id_rs1, id_rs2};

  always_comb begin
    op_a = id_rs1_data;
    op_b = id_rs2_data;
    case (forward_a_src)
      2'b01:   op_a = ex_fwd_data;
      2'b10:   op_a = mem_fwd_data;
      default: op_a = id_rs1_data;
    endcase
    case (forward_b_src)
      2'b01:   op_b = ex_fwd_data;
      2'b10:   op_b = mem_fwd_data;
      default: op_b = id_rs2_data;
    endcase
  end

  assign id_hold = stall & ~flush;
  assign bubble  = stall | flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      if (bubble) begin
        // Datapath registers keep stale values; only valid, rd and control are forced.
        ex_valid     <= 1'b0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_alu_op    <= '0;
        ex_alu_src   <= 1'b0;
      end else begin
        ex_valid     <= id_valid;
        ex_pc        <= id_pc;
        ex_rs1_val   <= op_a;
        ex_rs2_val   <= op_b;
        ex_imm       <= id_imm;
        ex_rd        <= id_valid ? id_rd : 5'd0;
        ex_reg_write <= id_valid & id_reg_write;
        ex_mem_read  <= id_valid & id_mem_read;
        ex_mem_write <= id_valid & id_mem_write;
        ex_alu_op    <= id_valid ? id_alu_op : 4'd0;
        ex_alu_src   <= id_valid & id_alu_src;
      end
      if (flush && id_valid && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_ONE;
      if (!flush && stall && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
  logic [3:0]  id_alu_op;
  logic        stall, flush;
  logic [1:0]  forward_a_src, forward_b_src;
  logic [31:0] ex_fwd_data, mem_fwd_data;

  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, id_hold;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_ex_valid, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_alu_src, s_id_hold;
  logic [31:0] s_ex_pc, s_ex_rs1_val, s_ex_rs2_val, s_ex_imm;
  logic [4:0]  s_ex_rd;
  logic [3:0]  s_ex_alu_op;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of what EX should hold after the next edge.
  logic        m_valid, m_rw, m_mr, m_mw, m_src;
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  logic [3:0]  m_op;
  int          m_scnt, m_fcnt, m_scnt4, m_fcnt4;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .stall(stall), .flush(flush),
    .forward_a_src(forward_a_src), .forward_b_src(forward_b_src), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_data(mem_fwd_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .id_hold(id_hold), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .stall(stall), .flush(flush),
    .forward_a_src(forward_a_src), .forward_b_src(forward_b_src), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_data(mem_fwd_data), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1_val(s_ex_rs1_val),
    .ex_rs2_val(s_ex_rs2_val), .ex_imm(s_ex_imm), .ex_rd(s_ex_rd), .ex_reg_write(s_ex_reg_write),
    .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_alu_op(s_ex_alu_op),
    .ex_alu_src(s_ex_alu_src), .id_hold(s_id_hold), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return ex_fwd_data;
    if (sel == 2'd2) return mem_fwd_data;
    return rf;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : maxv;
  endfunction

  // Advance one clock: update the model from the inputs seen at this edge, then settle.
  task automatic tick();
    if (!rst_n) begin
      {m_valid, m_rw, m_mr, m_mw, m_src} = '0;
      {m_pc, m_a, m_b, m_imm} = '0;
      m_rd = 0; m_op = 0;
      m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_fcnt4 = 0;
    end else if (flush || stall) begin
      m_valid = 0; m_rd = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      if (flush && id_valid) begin
        m_fcnt = sat_inc(m_fcnt, 65535); m_fcnt4 = sat_inc(m_fcnt4, 15);
      end
      if (!flush) begin
        m_scnt = sat_inc(m_scnt, 65535); m_scnt4 = sat_inc(m_scnt4, 15);
      end
    end else begin
      m_valid = id_valid;
      m_pc = id_pc; m_imm = id_imm;
      m_a = pick(forward_a_src, id_rs1_data);
      m_b = pick(forward_b_src, id_rs2_data);
      m_rd = id_valid ? id_rd : 5'd0;
      m_rw = id_valid && id_reg_write;
      m_mr = id_valid && id_mem_read;
      m_mw = id_valid && id_mem_write;
      m_op = id_alu_op; m_src = id_alu_src;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_id();
    id_valid = 1'b1;
    id_pc = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom_range(1, 31));
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
    id_alu_op = 4'($urandom); id_alu_src = 1'($urandom);
    ex_fwd_data = $urandom; mem_fwd_data = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; forward_a_src = 0; forward_b_src = 0;
    rand_id();
    tick(); tick();
    n_cmp++;
    if ({ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_reg_write, ex_mem_read,
         ex_mem_write, ex_alu_op, ex_alu_src, stall_cnt, flush_cnt} !== '0) begin
      n_err++; $display("FAIL reset_outputs: ex_valid=%0b ex_pc=%0h rd=%0d cnts=%0d/%0d want all 0",
                        ex_valid, ex_pc, ex_rd, stall_cnt, flush_cnt);
    end
    n_cmp++;
    if ({s_stall_cnt, s_flush_cnt, s_ex_valid} !== '0) begin
      n_err++; $display("FAIL reset_small: got %0h want 0", {s_stall_cnt, s_flush_cnt, s_ex_valid});
    end
    rst_n = 1;
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_pc !== m_pc) begin
      n_err++; $display("FAIL reset_release: valid=%0b pc=%0h want 1 %0h", ex_valid, ex_pc, m_pc);
    end
  endtask

  task automatic test_pass_through();
    rand_id();
    id_pc = 32'h100; id_rd = 5'd5; id_rs1_data = 32'd7; forward_a_src = 0; forward_b_src = 0;
    tick();
    n_cmp++;
    if (ex_pc !== 32'h100 || ex_rd !== 5'd5 || ex_rs1_val !== 32'd7 || ex_rs2_val !== m_b) begin
      n_err++; $display("FAIL pass_through: pc=%0h rd=%0d a=%0h b=%0h want 100 5 7 %0h",
                        ex_pc, ex_rd, ex_rs1_val, ex_rs2_val, m_b);
    end
  endtask

  task automatic test_forward();
    rand_id();
    forward_a_src = 2'b01; ex_fwd_data = 32'hAA; forward_b_src = 2'b10; mem_fwd_data = 32'hBB;
    tick();
    n_cmp++;
    if (ex_rs1_val !== 32'hAA || ex_rs2_val !== 32'hBB) begin
      n_err++; $display("FAIL forward_ex_mem: a=%0h b=%0h want aa bb", ex_rs1_val, ex_rs2_val);
    end
    forward_a_src = 2'b11; forward_b_src = 2'b11; id_rs1_data = 32'h1234; id_rs2_data = 32'h5678;
    tick();
    n_cmp++;
    if (ex_rs1_val !== 32'h1234 || ex_rs2_val !== 32'h5678) begin
      n_err++; $display("FAIL forward_code11: a=%0h b=%0h want 1234 5678", ex_rs1_val, ex_rs2_val);
    end
    forward_a_src = 0; forward_b_src = 0;
  endtask

  task automatic test_load_use();
    int prev_s;
    rand_id();
    id_mem_read = 1; stall = 1; prev_s = m_scnt;
    #1;
    n_cmp++;
    if (id_hold !== 1'b1) begin
      n_err++; $display("FAIL load_use_hold: got %0b want 1", id_hold);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 0 || ex_rd !== 0 || ex_mem_read !== 0 || ex_reg_write !== 0 || ex_mem_write !== 0
        || stall_cnt !== 16'(prev_s + 1)) begin
      n_err++; $display("FAIL load_use_bubble: v=%0b rd=%0d mr=%0b scnt=%0d want 0 0 0 %0d",
                        ex_valid, ex_rd, ex_mem_read, stall_cnt, prev_s + 1);
    end
    stall = 0;
    tick();
    n_cmp++;
    if (ex_valid !== 1 || ex_rd !== m_rd || ex_mem_read !== 1 || ex_pc !== m_pc) begin
      n_err++; $display("FAIL load_use_release: v=%0b rd=%0d mr=%0b pc=%0h want 1 %0d 1 %0h",
                        ex_valid, ex_rd, ex_mem_read, ex_pc, m_rd, m_pc);
    end
  endtask

  task automatic test_flush_stall();
    int prev_s, prev_f;
    rand_id();
    flush = 1; stall = 1; prev_s = m_scnt; prev_f = m_fcnt;
    #1;
    n_cmp++;
    if (id_hold !== 1'b0) begin
      n_err++; $display("FAIL flush_stall_hold: got %0b want 0", id_hold);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 0 || ex_rd !== 0 || ex_reg_write !== 0 || flush_cnt !== 16'(prev_f + 1)
        || stall_cnt !== 16'(prev_s)) begin
      n_err++; $display("FAIL flush_stall: v=%0b rd=%0d f=%0d s=%0d want 0 0 %0d %0d",
                        ex_valid, ex_rd, flush_cnt, stall_cnt, prev_f + 1, prev_s);
    end
    id_valid = 0;
    tick();
    n_cmp++;
    if (flush_cnt !== 16'(prev_f + 1)) begin
      n_err++; $display("FAIL flush_invalid: f=%0d want %0d", flush_cnt, prev_f + 1);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_id();
      id_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      forward_a_src = 2'($urandom); forward_b_src = 2'($urandom);
      #1;
      n_cmp++;
      if (id_hold !== (stall && !flush)) begin
        n_err++; $display("FAIL rand_hold[%0d]: got %0b want %0b", i, id_hold, stall && !flush);
      end
      tick();
      n_cmp++;
      if (ex_valid !== m_valid || ex_rd !== m_rd || ex_reg_write !== m_rw || ex_mem_read !== m_mr
          || ex_mem_write !== m_mw) begin
        n_err++; $display("FAIL rand_ctrl[%0d]: got v%0b rd%0d %0b%0b%0b want v%0b rd%0d %0b%0b%0b", i,
                          ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
                          m_valid, m_rd, m_rw, m_mr, m_mw);
      end
      n_cmp++;
      if (stall_cnt !== 16'(m_scnt) || flush_cnt !== 16'(m_fcnt) || s_stall_cnt !== 4'(m_scnt4)
          || s_flush_cnt !== 4'(m_fcnt4)) begin
        n_err++; $display("FAIL rand_cnt[%0d]: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d", i,
                          stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt, m_scnt, m_fcnt, m_scnt4, m_fcnt4);
      end
      if (m_valid) begin
        n_cmp++;
        if (ex_pc !== m_pc || ex_rs1_val !== m_a || ex_rs2_val !== m_b || ex_imm !== m_imm
            || ex_alu_op !== m_op || ex_alu_src !== m_src) begin
          n_err++; $display("FAIL rand_data[%0d]: pc%0h a%0h b%0h imm%0h want pc%0h a%0h b%0h imm%0h", i,
                            ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, m_pc, m_a, m_b, m_imm);
        end
      end
    end
    rst_n = 1; stall = 0; flush = 0;
  endtask

  task automatic test_saturation();
    rand_id();
    rst_n = 0; tick(); rst_n = 1;
    stall = 1;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
      n_err++; $display("FAIL saturation: small=%0d big=%0d want 15 20", s_stall_cnt, stall_cnt);
    end
    rst_n = 0;
    tick();
    n_cmp++;
    if (s_stall_cnt !== 4'd0 || stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL sat_reset: small=%0d big=%0d want 0 0", s_stall_cnt, stall_cnt);
    end
    rst_n = 1; stall = 0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_forward();
    test_load_use();
    test_flush_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
